// File: rtl/gpio_debounce.sv
// ---------------------------------------------------------------------------
// gpio_debounce
//
// Per-bit debounce filter and edge-event detector for external inputs that
// have already been synchronized into the clk domain. Each bit is fully
// independent: a bit's filtered level only changes after STABLE_CYCLES
// consecutive samples that differ from the current level. Every accepted
// change produces a registered one-cycle rise or fall pulse. Enabled pulses
// set a sticky interrupt-pending flag that software clears with a
// write-1-to-clear strobe.
//
// Parameters:
//   WIDTH          number of independent input bits
//   STABLE_CYCLES  consecutive mismatching samples needed to change level (>= 1)
//   INIT           reset value of every filtered level bit
//
// Ports:
//   clk          in   1      sole clock
//   rst_n        in   1      asynchronous active-low reset
//   sync_in      in   WIDTH  synchronized inputs
//   rise_en      in   WIDTH  per-bit rising-edge interrupt enable
//   fall_en      in   WIDTH  per-bit falling-edge interrupt enable
//   irq_clr      in   WIDTH  write-1-to-clear strobe for irq_pending
//   level        out  WIDTH  debounced level
//   rise_pulse   out  WIDTH  one-cycle pulse on a debounced 0->1 change
//   fall_pulse   out  WIDTH  one-cycle pulse on a debounced 1->0 change
//   irq_pending  out  WIDTH  sticky edge-event flags
//   irq          out  1      OR of irq_pending
// ---------------------------------------------------------------------------
module gpio_debounce #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned STABLE_CYCLES = 1000,
  parameter logic        INIT          = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sync_in,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  input  logic [WIDTH-1:0] irq_clr,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [WIDTH-1:0] irq_pending,
  output logic             irq
);

  localparam int unsigned   CW      = $clog2(STABLE_CYCLES + 1);
  // Terminal count: the mismatch seen on this edge is the STABLE_CYCLES-th.
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0]    r_cnt [WIDTH];
  logic [WIDTH-1:0] r_level;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic [WIDTH-1:0] r_pend;

  logic [CW-1:0]    w_cnt_nxt [WIDTH];
  logic [WIDTH-1:0] w_level_nxt;
  logic [WIDTH-1:0] w_rise_nxt;
  logic [WIDTH-1:0] w_fall_nxt;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_pend_nxt;

  // Filter next-state: a matching sample restarts the count; the count never
  // passes CNT_MAX because reaching it always accepts the change and reloads 0.
  always_comb begin
    w_level_nxt = r_level;
    w_rise_nxt  = '0;
    w_fall_nxt  = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (sync_in[i] == r_level[i]) begin
        w_cnt_nxt[i] = '0;
      end else if (r_cnt[i] == CNT_MAX) begin
        w_cnt_nxt[i]   = '0;
        w_level_nxt[i] = sync_in[i];
        w_rise_nxt[i]  = sync_in[i];
        w_fall_nxt[i]  = ~sync_in[i];
      end else begin
        w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
      end
    end
  end

  // Pending flags: a set on the same edge as a clear wins so no event is lost.
  // Enables are only looked at while a pulse is present.
  always_comb begin
    w_set      = (r_rise & rise_en) | (r_fall & fall_en);
    w_pend_nxt = w_set | (r_pend & ~irq_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        r_cnt[i] <= '0;
      end
      r_level <= {WIDTH{INIT}};
      r_rise  <= '0;
      r_fall  <= '0;
      r_pend  <= '0;
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
      r_level <= w_level_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  assign level       = r_level;
  assign rise_pulse  = r_rise;
  assign fall_pulse  = r_fall;
  assign irq_pending = r_pend;
  assign irq         = |r_pend;

endmodule

// File: tb/tb_gpio_debounce.sv
// ---------------------------------------------------------------------------
// tb_gpio_debounce
//
// Bench for gpio_debounce with WIDTH=4, STABLE_CYCLES=4, INIT=0. A window
// reference model (the last STABLE_CYCLES samples since reset must all differ
// from the level for it to flip) predicts every output each cycle; directed
// steps add fixed expectations for the interesting corner cases, followed by
// a randomized phase.
// ---------------------------------------------------------------------------
module tb_gpio_debounce;

  localparam int W  = 4;
  localparam int SC = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] sync_in = '0;
  logic [W-1:0] rise_en = '0;
  logic [W-1:0] fall_en = '0;
  logic [W-1:0] irq_clr = '0;
  logic [W-1:0] level;
  logic [W-1:0] rise_pulse;
  logic [W-1:0] fall_pulse;
  logic [W-1:0] irq_pending;
  logic         irq;

  int checks = 0;
  int errors = 0;

  gpio_debounce #(
    .WIDTH        (W),
    .STABLE_CYCLES(SC),
    .INIT         (1'b0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sync_in    (sync_in),
    .rise_en    (rise_en),
    .fall_en    (fall_en),
    .irq_clr    (irq_clr),
    .level      (level),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .irq_pending(irq_pending),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [W-1:0] hist [SC];   // hist[0] = most recent sample
  int           hcnt;        // samples taken since reset
  logic [W-1:0] m_level, m_rise, m_fall, m_pend;

  // Level after this edge: flip a bit when the newest SC samples (including
  // the one taken now) all differ from the current level.
  function automatic logic [W-1:0] next_level(input logic [W-1:0] cur,
                                              input logic [W-1:0] now,
                                              input int           have);
    logic [W-1:0] res;
    logic [W-1:0] smp;
    res = cur;
    if (have + 1 >= SC) begin
      for (int b = 0; b < W; b++) begin
        logic all_diff;
        all_diff = 1'b1;
        for (int j = 0; j < SC; j++) begin
          smp = (j == 0) ? now : hist[j-1];
          if (smp[b] == cur[b]) all_diff = 1'b0;
        end
        if (all_diff) res[b] = ~cur[b];
      end
    end
    return res;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < SC; j++) hist[j] <= '0;
      hcnt    <= 0;
      m_level <= '0;
      m_rise  <= '0;
      m_fall  <= '0;
      m_pend  <= '0;
    end else begin
      hist[0] <= sync_in;
      for (int j = 1; j < SC; j++) hist[j] <= hist[j-1];
      hcnt    <= (hcnt < SC) ? hcnt + 1 : hcnt;
      m_level <= next_level(m_level, sync_in, hcnt);
      m_rise  <= next_level(m_level, sync_in, hcnt) & ~m_level;
      m_fall  <= ~next_level(m_level, sync_in, hcnt) & m_level;
      m_pend  <= (m_rise & rise_en) | (m_fall & fall_en) | (m_pend & ~irq_clr);
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".level"}, 32'(level),       32'(m_level));
    chk({tag, ".rise"},  32'(rise_pulse),  32'(m_rise));
    chk({tag, ".fall"},  32'(fall_pulse),  32'(m_fall));
    chk({tag, ".pend"},  32'(irq_pending), 32'(m_pend));
    chk({tag, ".irq"},   32'(irq),         32'(|m_pend));
    chk({tag, ".excl"},  32'(rise_pulse & fall_pulse), 32'(0));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    @(negedge clk);
    check_model(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] pat;

    // Reset with all inputs high: everything stays at its reset value.
    rst_n   = 1'b0;
    sync_in = 4'hF;
    rise_en = 4'b0100;
    fall_en = 4'b1000;
    repeat (3) tick("rst");
    chk("rst_level", 32'(level), 32'(0));
    chk("rst_rise",  32'(rise_pulse), 32'(0));
    chk("rst_fall",  32'(fall_pulse), 32'(0));
    chk("rst_pend",  32'(irq_pending), 32'(0));
    chk("rst_irq",   32'(irq), 32'(0));

    sync_in = 4'h0;
    rst_n   = 1'b1;
    tick("idle");

    // Glitch of 3 cycles on bit 0 is rejected.
    sync_in[0] = 1'b1;
    repeat (3) begin
      tick("glitch_hi");
      chk("glitch_lvl", 32'(level[0]), 32'(0));
    end
    sync_in[0] = 1'b0;
    repeat (4) begin
      tick("glitch_lo");
      chk("glitch_lvl", 32'(level[0]), 32'(0));
      chk("glitch_rise", 32'(rise_pulse[0]), 32'(0));
    end

    // Bounce on bit 1: 1,1,1,0 restarts, then 1,1,1,1 is accepted.
    pat = 8'b1111_0111;  // applied LSB first
    for (int k = 0; k < 8; k++) begin
      sync_in[1] = pat[k];
      tick("bounce");
      if (k < 7) begin
        chk("bounce_lvl_early", 32'(level[1]), 32'(0));
      end else begin
        chk("bounce_lvl_rise", 32'(level[1]), 32'(1));
        chk("bounce_pulse", 32'(rise_pulse[1]), 32'(1));
      end
    end
    tick("bounce_after");
    chk("bounce_pulse_one", 32'(rise_pulse[1]), 32'(0));
    chk("bounce_lvl_hold", 32'(level[1]), 32'(1));

    // Interrupt path on bit 2 (rise enabled, fall disabled).
    sync_in[2] = 1'b1;
    repeat (3) begin
      tick("irq2_wait");
      chk("irq2_no_pulse", 32'(rise_pulse[2]), 32'(0));
    end
    tick("irq2_pulse");
    chk("irq2_rise", 32'(rise_pulse[2]), 32'(1));
    chk("irq2_pend_early", 32'(irq_pending[2]), 32'(0));
    tick("irq2_set");
    chk("irq2_pend", 32'(irq_pending[2]), 32'(1));
    chk("irq2_irq", 32'(irq), 32'(1));
    irq_clr[2] = 1'b1;
    tick("irq2_clr");
    chk("irq2_cleared", 32'(irq_pending[2]), 32'(0));
    irq_clr[2] = 1'b0;
    sync_in[2] = 1'b0;
    repeat (3) tick("irq2_fall_wait");
    tick("irq2_fall");
    chk("irq2_fall_pulse", 32'(fall_pulse[2]), 32'(1));
    tick("irq2_after_fall");
    chk("irq2_fall_no_set", 32'(irq_pending[2]), 32'(0));
    chk("irq2_irq_low", 32'(irq), 32'(0));

    // Set/clear collision on bit 3 (fall enabled).
    sync_in[3] = 1'b1;
    repeat (4) tick("col_rise");
    sync_in[3] = 1'b0;
    repeat (4) tick("col_fall");
    chk("col_fall_pulse", 32'(fall_pulse[3]), 32'(1));
    irq_clr[3] = 1'b1;
    tick("col_edge");
    chk("col_set_wins", 32'(irq_pending[3]), 32'(1));
    irq_clr[3] = 1'b0;
    tick("col_hold");
    chk("col_hold", 32'(irq_pending[3]), 32'(1));
    irq_clr[3] = 1'b1;
    tick("col_clear");
    chk("col_cleared", 32'(irq_pending[3]), 32'(0));
    irq_clr[3] = 1'b0;

    // Mid-count reset on bit 0: partial count is discarded.
    sync_in[0] = 1'b1;
    repeat (2) tick("mid_pre");
    rst_n = 1'b0;
    tick("mid_rst");
    chk("mid_rst_lvl", 32'(level[0]), 32'(0));
    rst_n = 1'b1;
    repeat (3) begin
      tick("mid_wait");
      chk("mid_lvl_low", 32'(level[0]), 32'(0));
    end
    tick("mid_rise");
    chk("mid_lvl_high", 32'(level[0]), 32'(1));
    chk("mid_pulse", 32'(rise_pulse[0]), 32'(1));

    // Randomized phase: sporadic toggles, enables and clears, one reset.
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < W; b++) begin
        if ($urandom_range(0, 4) == 0) sync_in[b] = ~sync_in[b];
        irq_clr[b] = ($urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 29) == 0) begin
        rise_en = W'($urandom);
        fall_en = W'($urandom);
      end
      rst_n = !(c >= 300 && c < 302);
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
